// File: rtl/qam_coherent_demod.sv
// rtl/qam_coherent_demod.sv - coherent 16-QAM demodulator: mixer, integrate-and-dump, slicer, serializer
module qam_coherent_demod #(
   parameter int SPS   = 16,
   parameter int ACC_W = 20,
   parameter int THR   = 4096
) (
   input  logic               clk,
   input  logic               rst,
   input  logic signed [11:0] RxSig,
   input  logic signed [9:0]  CosWave,
   input  logic signed [9:0]  SinWave,
   input  logic               sym_start,
   output logic [1:0]         SigI,
   output logic [1:0]         SigQ,
   output logic               sym_valid,
   output logic               m_rec,
   output logic               bit_valid,
   output logic               locked,
   output logic               align_err,
   output logic               sat
);

   localparam int CW = (SPS > 1) ? $clog2(SPS) : 1;
   localparam logic [CW-1:0] LAST = CW'(SPS - 1);
   localparam logic signed [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
   localparam logic signed [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};
   localparam logic signed [ACC_W:0]   THR_P   = (ACC_W+1)'(THR);
   localparam logic signed [ACC_W:0]   THR_N   = -(ACC_W+1)'(THR);

   typedef enum logic {ACQ, TRACK} state_t;

   state_t                  state;
   logic signed [21:0]      prod_i, prod_q;
   logic signed [12:0]      pI, pQ;
   logic                    ss_d;
   logic signed [ACC_W-1:0] accI, accQ;
   logic signed [ACC_W-1:0] sum_i, sum_q, ext_i, ext_q;
   logic                    ov_i, ov_q;
   logic [CW-1:0]           cnt;
   logic [1:0]              dec_i, dec_q;
   logic [2:0]              shreg;
   logic [1:0]              bits_left;

   assign prod_i = RxSig * CosWave;
   assign prod_q = RxSig * SinWave;
   assign ext_i  = {{(ACC_W-13){pI[12]}}, pI};
   assign ext_q  = {{(ACC_W-13){pQ[12]}}, pQ};

   function automatic logic signed [ACC_W-1:0] sat_add(
      input  logic signed [ACC_W-1:0] a,
      input  logic signed [12:0]      b,
      output logic                    ov
   );
      logic signed [ACC_W:0] s;
      s  = {a[ACC_W-1], a} + {{(ACC_W-12){b[12]}}, b};
      ov = s[ACC_W] != s[ACC_W-1];
      if (ov)
         return s[ACC_W] ? ACC_MIN : ACC_MAX;
      return s[ACC_W-1:0];
   endfunction

   function automatic logic [1:0] slice(input logic signed [ACC_W-1:0] a);
      logic signed [ACC_W:0] x;
      x = {a[ACC_W-1], a};
      if (x >= THR_P)       return 2'b11;
      else if (!a[ACC_W-1]) return 2'b10;
      else if (x >= THR_N)  return 2'b01;
      return 2'b00;
   endfunction

   always_comb begin
      ov_i  = 1'b0;
      ov_q  = 1'b0;
      sum_i = sat_add(accI, pI, ov_i);
      sum_q = sat_add(accQ, pQ, ov_q);
      dec_i = slice(accI);
      dec_q = slice(accQ);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state     <= ACQ;
         pI        <= '0;
         pQ        <= '0;
         ss_d      <= 1'b0;
         accI      <= '0;
         accQ      <= '0;
         cnt       <= '0;
         SigI      <= 2'b00;
         SigQ      <= 2'b00;
         sym_valid <= 1'b0;
         m_rec     <= 1'b0;
         bit_valid <= 1'b0;
         locked    <= 1'b0;
         align_err <= 1'b0;
         sat       <= 1'b0;
         shreg     <= '0;
         bits_left <= '0;
      end else begin
         // arithmetic >>>9 of the 22-bit product kept as 13 bits
         pI        <= prod_i[21:9];
         pQ        <= prod_q[21:9];
         ss_d      <= sym_start;
         sym_valid <= 1'b0;
         align_err <= 1'b0;

         if (bits_left != 2'd0) begin
            m_rec     <= shreg[2];
            shreg     <= {shreg[1:0], 1'b0};
            bits_left <= bits_left - 2'd1;
            bit_valid <= 1'b1;
         end else begin
            m_rec     <= 1'b0;
            bit_valid <= 1'b0;
         end

         case (state)
            ACQ: begin
               if (ss_d) begin
                  accI   <= ext_i;
                  accQ   <= ext_q;
                  cnt    <= '0;
                  state  <= TRACK;
                  locked <= 1'b1;
               end
            end
            TRACK: begin
               // the boundary wins over sym_start so an on-time marker is not an error
               if (cnt == LAST) begin
                  sym_valid <= 1'b1;
                  SigI      <= dec_i;
                  SigQ      <= dec_q;
                  m_rec     <= dec_i[1];
                  shreg     <= {dec_i[0], dec_q};
                  bits_left <= 2'd3;
                  bit_valid <= 1'b1;
                  accI      <= ext_i;
                  accQ      <= ext_q;
                  cnt       <= '0;
               end else if (ss_d) begin
                  align_err <= 1'b1;
                  accI      <= ext_i;
                  accQ      <= ext_q;
                  cnt       <= '0;
               end else begin
                  accI <= sum_i;
                  accQ <= sum_q;
                  cnt  <= cnt + CW'(1);
                  if (ov_i || ov_q)
                     sat <= 1'b1;
               end
            end
            default: state <= ACQ;
         endcase
      end
   end

endmodule

// File: doc/qam_coherent_demod.md
QAM_COHERENT_DEMOD -- requirements
Module: qam_coherent_demod

Interface
REQ-001 The block SHALL have parameter SPS, default 16: carrier samples per symbol; legal range 4..256.
REQ-002 The block SHALL have parameter ACC_W, default 20: width of each signed integrate-and-dump accumulator.
REQ-003 The block SHALL have parameter THR, default 4096: positive decision threshold applied symmetrically to both branches.
REQ-004 The block SHALL have the port clk  in  1: single clock; all state updates on its rising edge.
REQ-005 The block SHALL have the port rst  in  1: asynchronous, active-low reset.
REQ-006 The block SHALL have the port RxSig  in  12: received composite QAM sample (I_mod + Q_mod), signed two's complement.
REQ-007 The block SHALL have the port CosWave  in  10: local cosine reference, signed two's complement, same phase as the modulator carrier.
REQ-008 The block SHALL have the port SinWave  in  10: local sine reference, signed two's complement.
REQ-009 The block SHALL have the port sym_start  in  1: one-cycle pulse marking that the current RxSig is sample 0 of a symbol.
REQ-010 The block SHALL have the port SigI  out  2: recovered I code; code k denotes level 2k-3.
REQ-011 The block SHALL have the port SigQ  out  2: recovered Q code; same encoding as SigI.
REQ-012 The block SHALL have the port sym_valid  out  1: one-cycle pulse when SigI/SigQ update.
REQ-013 The block SHALL have the port m_rec  out  1: recovered serial bit stream.
REQ-014 The block SHALL have the port bit_valid  out  1: high on each cycle m_rec carries a bit.
REQ-015 The block SHALL have the port locked  out  1: high once symbol timing has been acquired.
REQ-016 The block SHALL have the port align_err  out  1: one-cycle pulse on an early sym_start.
REQ-017 The block SHALL have the port sat  out  1: sticky flag, set on any accumulator saturation.

Function
REQ-018 Mixer stage (pipeline stage 1) SHALL register pI = (RxSig*CosWave)>>>9 and pQ = (RxSig*SinWave)>>>9; the full product is 22-bit signed, the shift is arithmetic, and the result is kept as 13-bit signed; sym_start SHALL be delayed one cycle alongside.
REQ-019 The state machine SHALL have states ACQ and TRACK; it SHALL leave reset in ACQ, with locked = 0 in ACQ and locked = 1 in TRACK.
REQ-020 In ACQ, the block SHALL ignore mixer outputs until the delayed sym_start; on that cycle it SHALL load accI = pI and accQ = pQ, set sample counter cnt = 0, and go to TRACK.
REQ-021 In TRACK, each cycle SHALL add pI/pQ into the accumulators and increment cnt; addition SHALL saturate to the ACC_W signed limits and set sat.
REQ-022 When cnt = SPS-1 is accumulated, the next cycle SHALL present the decisions on SigI/SigQ with sym_valid = 1; in that same cycle the accumulators SHALL reload with that cycle's pI/pQ and cnt SHALL become 0 (continuous, no dead cycle).
REQ-023 Decision per branch SHALL be: acc >= THR gives 2'b11; 0 <= acc < THR gives 2'b10; -THR <= acc < 0 gives 2'b01; acc < -THR gives 2'b00.
REQ-024 Total latency SHALL be SPS+1 cycles: from the cycle sym_start is presented at the input to the cycle sym_valid is high.
REQ-025 A delayed sym_start arriving in TRACK with cnt != SPS-1 SHALL pulse align_err, discard the partial symbol (no sym_valid), and restart the accumulators at sample 0 with the current pI/pQ.
REQ-026 A delayed sym_start coinciding with the expected boundary SHALL be treated as normal, with no align_err.
REQ-027 Serializer: on sym_valid, the block SHALL load {SigI[1], SigI[0], SigQ[1], SigQ[0]} and emit one bit per cycle MSB first on m_rec; bit_valid SHALL be high for exactly 4 cycles, the first coinciding with sym_valid.
REQ-028 An align_err SHALL NOT abort a serialization in progress.
REQ-029 SigI/SigQ SHALL hold their value between sym_valid pulses.

Reset
REQ-030 Asserting rst low SHALL immediately force: SigI = SigQ = 2'b00, sym_valid = 0, m_rec = 0, bit_valid = 0, locked = 0, align_err = 0, sat = 0, accumulators = 0, cnt = 0, mixer registers = 0, state = ACQ.
REQ-031 Reset mid-symbol or mid-serialization SHALL discard all partial data; after release, the block SHALL reacquire only on a new sym_start.

Verification
REQ-032 Scenario: RxSig = 1000, CosWave = 511, SinWave = 0, sym_start at cycle 0 -> pI = 998 and accI = 15968 (>= THR); at cycle 17: sym_valid = 1, SigI = 11, SigQ = 10; m_rec = 1, 1, 1, 0 on cycles 17-20.
REQ-033 Scenario: RxSig = -1000, CosWave = 511, SinWave = 511 -> SigI = 00 and SigQ = 00; m_rec = 0000.
REQ-034 Scenario: sym_start at cycle 0, then again at cycle 8 -> align_err pulses at cycle 9; no sym_valid at cycle 17; next sym_valid at cycle 25.
REQ-035 Scenario: sym_start every 16 cycles -> align_err never pulses; sym_valid every 16 cycles; locked = 1 from cycle 1.
REQ-036 Scenario: rst low during cycle 10 of a symbol -> all outputs return to reset values at once; no sym_valid until 17 cycles after the next sym_start.
REQ-037 Scenario: ACC_W = 14, RxSig = 2047, CosWave = 511 -> sat = 1, accI pinned at 8191, SigI = 11.
